// File: rtl/niosii_cpu_mul_result_combiner_if.sv
// ----------------------------------------------------------------------------
// niosii_cpu_mul_result_combiner_if
//
// Purpose:
//   Bundles the two valid/ready streams of the multiplier result combiner:
//   the partial-product input stream coming from the M-stage multiplier cell
//   and the assembled-result output stream going to the writeback mux.
//
// Signals:
//   in_valid       partial products and tag are valid this cycle
//   in_ready       combiner accepts the input this cycle
//   M_mul_cell_p1  src1[15:0]  * src2[15:0]  (unsigned, 32 bits)
//   M_mul_cell_p2  src1[15:0]  * src2[31:16] (unsigned, 32 bits)
//   M_mul_cell_p3  src1[31:16] * src2[15:0]  (unsigned, 32 bits)
//   in_tag         destination register index travelling with the operands
//   out_valid      out_result/out_tag hold a valid product
//   out_ready      downstream consumes the result this cycle
//   out_result     low 32 bits of src1*src2
//   out_tag        tag of out_result
//
// Modports:
//   slave   the combiner itself (consumes partial products, produces results)
//   master  the surrounding pipeline / testbench
// ----------------------------------------------------------------------------
interface niosii_cpu_mul_result_combiner_if #(
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      M_mul_cell_p1;
  logic [31:0]      M_mul_cell_p2;
  logic [31:0]      M_mul_cell_p3;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid,
    output in_ready,
    input  M_mul_cell_p1,
    input  M_mul_cell_p2,
    input  M_mul_cell_p3,
    input  in_tag,
    output out_valid,
    input  out_ready,
    output out_result,
    output out_tag
  );

  modport master (
    output in_valid,
    input  in_ready,
    output M_mul_cell_p1,
    output M_mul_cell_p2,
    output M_mul_cell_p3,
    output in_tag,
    input  out_valid,
    output out_ready,
    input  out_result,
    input  out_tag
  );

endinterface

// File: rtl/niosii_cpu_mul_result_combiner.sv
// ----------------------------------------------------------------------------
// niosii_cpu_mul_result_combiner
//
// Purpose:
//   Consumer end of the CPU multiplier cell. Combines the three 16x16 partial
//   products (lo*lo, lo*hi, hi*lo) into the low 32 bits of the 32x32 product.
//   Two-stage pipeline with valid/ready handshaking on both sides; a tag
//   (destination register index) travels with every product, and a flush
//   input kills every in-flight product.
//
//   S1: cross16 = p2[15:0] + p3[15:0] (carry out dropped); p1, cross16 and
//       tag are registered.
//   S2: result = p1 + {cross16, 16'h0000}; result and tag drive the outputs.
//   Only the low halves of p2/p3 can reach bits [31:16] of the product, so
//   their upper halves are ignored.
//
// Ports:
//   clk      single clock, all state changes on the rising edge
//   reset_n  synchronous, active-low reset
//   flush    synchronous kill of both pipeline stages
//   bus      slave side of niosii_cpu_mul_result_combiner_if (input and
//            output valid/ready streams, partial products, tag, result)
//
// Parameters:
//   TAG_W    width of the tag carried with each product
// ----------------------------------------------------------------------------
module niosii_cpu_mul_result_combiner #(
  parameter int TAG_W = 5
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  flush,
  niosii_cpu_mul_result_combiner_if.slave       bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             s1_valid_reg;
  logic [31:0]      s1_p1_reg;
  logic [15:0]      s1_cross16_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [31:0]      s2_result_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  // --------------------------------------------------------------------------
  // Handshake / advance control
  // --------------------------------------------------------------------------
  logic             s2_adv;
  logic             s1_adv;
  logic             in_ready_int;
  logic             accept;
  logic             s2_load;
  logic             s1_valid_next;
  logic             s2_valid_next;
  logic [15:0]      cross16_next;
  logic [31:0]      result_next;

  // The upper halves of p2/p3 only contribute to product bits >= 32.
  logic             unused_hi_bits;
  assign unused_hi_bits = ^{bus.M_mul_cell_p2[31:16], bus.M_mul_cell_p3[31:16]};

  always_comb begin
    // S2 can take new data when empty or when its result leaves this cycle.
    s2_adv       = !s2_valid_reg | bus.out_ready;
    s1_adv       = s1_valid_reg & s2_adv;

    // Depends only on state, flush, reset_n and out_ready -- never on
    // in_valid, so no combinational loop can form through the producer.
    in_ready_int = (!s1_valid_reg | s2_adv) & !flush & reset_n;
    accept       = bus.in_valid & in_ready_int;

    // Flush freezes the data registers; only the valid bits are cleared.
    s2_load      = s1_adv & !flush;

    if (flush) begin
      s1_valid_next = 1'b0;
    end else if (accept) begin
      s1_valid_next = 1'b1;
    end else if (s1_adv) begin
      s1_valid_next = 1'b0;
    end else begin
      s1_valid_next = s1_valid_reg;
    end

    if (flush) begin
      s2_valid_next = 1'b0;
    end else if (s2_adv) begin
      s2_valid_next = s1_valid_reg;
    end else begin
      s2_valid_next = s2_valid_reg;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_comb begin
    // 16-bit sum: the carry into bit 32 of the product is discarded here.
    cross16_next = bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];
    result_next  = s1_p1_reg + {s1_cross16_reg, 16'h0000};
  end

  // --------------------------------------------------------------------------
  // Registers (reset > flush > advance/stall)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_reg   <= 1'b0;
      s1_p1_reg      <= 32'h0;
      s1_cross16_reg <= 16'h0;
      s1_tag_reg     <= '0;
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= 32'h0;
      s2_tag_reg     <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s2_valid_reg <= s2_valid_next;

      // Data registers load only when their stage takes a new product, so a
      // stalled result stays bit-stable on the outputs.
      if (accept) begin
        s1_p1_reg      <= bus.M_mul_cell_p1;
        s1_cross16_reg <= cross16_next;
        s1_tag_reg     <= bus.in_tag;
      end

      if (s2_load) begin
        s2_result_reg <= result_next;
        s2_tag_reg    <= s1_tag_reg;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = s2_valid_reg;
  assign bus.out_result = s2_result_reg;
  assign bus.out_tag    = s2_tag_reg;

endmodule
